// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, access sizes, funct3 codes.
// Misaligned-trap behaviour is selected in load_store_unit by LSU_MISALIGN_TRAP_EN.
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } lsu_state_e;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } lsu_size_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return BYTE;
      2'b01:   return HALF;
      default: return WORD;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (size_of(funct3))
      HALF:    return addr_lo[0];
      WORD:    return (addr_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the load/store unit: extracts and extends load data,
// and merges a byte/half store into the word read back from memory.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'b00: byte_sel = rdata[7:0];
      2'b01: byte_sel = rdata[15:8];
      2'b10: byte_sel = rdata[23:16];
      2'b11: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // funct3[2] selects zero-extension for LBU/LHU
    case (size_of(funct3))
      BYTE:    load_data = {{24{byte_sel[7] & ~funct3[2]}}, byte_sel};
      HALF:    load_data = {{16{half_sel[15] & ~funct3[2]}}, half_sel};
      default: load_data = rdata;
    endcase

    merge_data = rdata;
    case (size_of(funct3))
      BYTE: begin
        case (addr_lo)
          2'b00: merge_data[7:0]   = wdata[7:0];
          2'b01: merge_data[15:8]  = wdata[7:0];
          2'b10: merge_data[23:16] = wdata[7:0];
          2'b11: merge_data[31:24] = wdata[7:0];
          default: merge_data = rdata;
        endcase
      end
      HALF: begin
        if (addr_lo[1]) merge_data[31:16] = wdata[15:0];
        else            merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one request at a time to a word-wide data memory, SB/SH via read-modify-write.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses with resp_error.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int MEM_AW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_error,
  output logic              mem_write_enable,
  output logic [MEM_AW-1:0] mem_address,
  output logic [XLEN-1:0]   mem_write_data,
  input  logic [XLEN-1:0]   mem_read_data
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, merge_q;
  logic [31:0] load_data, merge_data;
  logic        accept, trap;

  assign accept = req_valid & req_ready;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = misaligned(req_funct3, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rdata      (mem_read_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (trap)                              state_d = RESP;
          else if (!req_we)                      state_d = LOAD;
          else if (size_of(req_funct3) == WORD)  state_d = STORE;
          else                                   state_d = RMW_RD;
        end
      end
      LOAD:    state_d = RESP;
      RMW_RD:  state_d = STORE;
      STORE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready        = (state_q == IDLE);
    resp_valid       = (state_q == RESP);
    mem_write_enable = (state_q == STORE);
    mem_address      = MEM_AW'(addr_q[31:2]);
    mem_write_data   = (size_of(funct3_q) == WORD) ? wdata_q : merge_q;
  end

  // Request latch, merge word and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q   <= req_funct3;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        resp_rdata <= '0;
        resp_error <= trap;
      end
      if (state_q == LOAD)   resp_rdata <= load_data;
      if (state_q == RMW_RD) merge_q    <= merge_data;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios plus random traffic against a byte-lane memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, mem_write_enable;
  logic [31:0] resp_rdata, mem_address, mem_write_data, mem_read_data;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_idx = '0;
  logic [31:0] pl_val = '0;
  int          wr_count = 0;
  logic [31:0] last_wr_addr = '0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .MEM_AW(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_we           (req_we),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  // data_memory model: combinational read, word write on posedge
  assign mem_read_data = mem[mem_address[3:0]];
  always @(posedge clk) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else if (mem_write_enable) begin
      mem[mem_address[3:0]] <= mem_write_data;
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_address;
    end
  end

  function automatic int size_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic model_mis(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] addr);
    longint v;
    int nb;
    nb = size_bytes(f3);
    if (nb == 4) return w;
    v = (longint'(w) >> (8 * ((addr % 4) / nb) * nb)) % (longint'(1) << (8 * nb));
    if (!f3[2] && v >= (longint'(1) << (8 * nb - 1))) v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [31:0] addr);
    longint mask;
    int nb, sh;
    nb = size_bytes(f3);
    if (nb == 4) return d;
    sh   = 8 * ((addr % 4) / nb) * nb;
    mask = ((longint'(1) << (8 * nb)) - 1) << sh;
    return 32'((longint'(old) & ~mask) | ((longint'(d) << sh) & mask));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = idx[3:0];
    pl_val = v;
    @(posedge clk);
    #1 pl_en = 1'b0;
    ref_mem[idx] = v;
  endtask

  task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, output logic [31:0] rd);
    int n, wc0, idx, exp_lat;
    logic mis;
    logic [31:0] exp_rd;
    idx = int'(addr[5:2]);
    mis = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = model_mis(f3, addr);
`endif
    exp_lat = mis ? 1 : (!we || size_bytes(f3) == 4) ? 2 : 3;
    exp_rd  = (we || mis) ? 32'h0 : model_load(ref_mem[idx], f3, addr);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 10) begin @(negedge clk); n++; end
    check({tag, "_ready"}, 32'(req_ready), 32'h1);
    wc0 = wr_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 10) begin @(posedge clk); #1; n++; end
    rd = resp_rdata;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_err"}, 32'(resp_error), 32'(mis));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(resp_valid), 32'h0);
    check({tag, "_writes"}, 32'(wr_count - wc0), 32'(we && !mis));
    if (we && !mis) begin
      ref_mem[idx] = model_store(ref_mem[idx], wd, f3, addr);
      check({tag, "_word"}, mem[idx], ref_mem[idx]);
      check({tag, "_waddr"}, last_wr_addr, 32'(idx));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd;
    logic [2:0]  ld_f3 [5];
    logic [2:0]  st_f3 [3];
    int          wc0;
    ld_f3 = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    st_f3 = '{F3_B, F3_H, F3_W};

    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rst_resp_error", 32'(resp_error), 32'h0);
    check("rst_we", 32'(mem_write_enable), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    for (int i = 0; i < 16; i++) preload(i, $urandom);
    @(negedge clk);
    rst_n = 1'b1;

    preload(1, 32'h8000_80F0);
    run_op("lb4", 1'b0, F3_B, 32'h4, 32'h0, rd);
    check("lb4_const", rd, 32'hFFFF_FFF0);
    run_op("lbu4", 1'b0, F3_BU, 32'h4, 32'h0, rd);
    check("lbu4_const", rd, 32'h0000_00F0);
    run_op("lh6", 1'b0, F3_H, 32'h6, 32'h0, rd);
    check("lh6_const", rd, 32'hFFFF_8000);
    run_op("lw4", 1'b0, F3_W, 32'h4, 32'h0, rd);
    check("lw4_const", rd, 32'h8000_80F0);

    run_op("sw8", 1'b1, F3_W, 32'h8, 32'hDEAD_BEEF, rd);
    run_op("lw8", 1'b0, F3_W, 32'h8, 32'h0, rd);
    check("lw8_const", rd, 32'hDEAD_BEEF);

    run_op("sb9", 1'b1, F3_B, 32'h9, 32'h55, rd);
    check("sb9_const", mem[2], 32'hDEAD_55EF);
    run_op("sha", 1'b1, F3_H, 32'hA, 32'h1234, rd);
    check("sha_const", mem[2], 32'h1234_55EF);

    // back-to-back loads with req_valid held high throughout
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W;
    for (int i = 0; i < 10; i++) begin
      req_addr = 32'(i * 4);
      check("b2b_ready_idle", 32'(req_ready), 32'h1);
      @(posedge clk); #1;
      check("b2b_ready_busy1", 32'(req_ready), 32'h0);
      @(posedge clk); #1;
      check("b2b_ready_busy2", 32'(req_ready), 32'h0);
      check("b2b_resp", 32'(resp_valid), 32'h1);
      check("b2b_rdata", resp_rdata, ref_mem[i]);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = 1'b0;

    // reset asserted while the SB sits in its read phase
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h9; req_wdata = 32'hAA;
    wc0 = wr_count;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rmw_rst_we", 32'(mem_write_enable), 32'h0);
    check("rmw_rst_resp_valid", 32'(resp_valid), 32'h0);
    check("rmw_rst_rdata", resp_rdata, 32'h0);
    check("rmw_rst_err", 32'(resp_error), 32'h0);
    check("rmw_rst_ready", 32'(req_ready), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("rmw_rst_nowrite", 32'(wr_count - wc0), 32'h0);
    check("rmw_rst_word", mem[2], ref_mem[2]);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("post_rst_sb", 1'b1, F3_B, 32'h9, 32'h77, rd);

    run_op("lw5", 1'b0, F3_W, 32'h5, 32'h0, rd);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw5_const", rd, 32'h0);
`else
    check("lw5_const", rd, 32'h8000_80F0);
`endif

    for (int k = 0; k < 40; k++) begin
      logic        we;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      a  = 32'($urandom_range(0, 63));
      if (we) run_op("rnd_st", 1'b1, st_f3[$urandom_range(0, 2)], a, $urandom, rd);
      else    run_op("rnd_ld", 1'b0, ld_f3[$urandom_range(0, 4)], a, 32'h0, rd);
    end
    for (int i = 0; i < 16; i++) check("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
